// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding request FSM (REQ/WAIT/DRAIN) with a registered output slot.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_idata,
   output logic [31:0] if_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_inflight_pc;
   logic        r_if_valid;
   logic [31:0] r_if_idata;
   logic [31:0] r_if_pc;

   logic        w_req_valid;
   logic        w_handshake;
   logic        w_load;
   logic        w_consume;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_REQ;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      // The reset term keeps the request low while reset is held, even though state already reads REQ.
      w_req_valid = reset && (r_state == S_REQ) && (!r_if_valid || !stall);
      w_handshake = w_req_valid && imem_req_ready;
      w_load      = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
      w_consume   = r_if_valid && !stall;
      case (r_state)
         S_REQ: begin
            if (w_handshake) begin
               w_state_nxt = redirect_valid ? S_DRAIN : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               w_state_nxt = S_REQ;
            end else if (redirect_valid) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (imem_rsp_valid) begin
               w_state_nxt = S_REQ;
            end
         end
         default: w_state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc          <= RESET_PC;
         r_inflight_pc <= '0;
      end else begin
         if (w_handshake) begin
            r_inflight_pc <= r_pc;
         end
         if (redirect_valid) begin
            r_pc <= redirect_pc;
         end else if (w_handshake) begin
            r_pc <= r_pc + 32'd4;
         end
      end
   end

   // Redirect flushes the slot regardless of stall; otherwise a load wins over consumption.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_if_valid <= 1'b0;
         r_if_idata <= '0;
         r_if_pc    <= '0;
      end else if (redirect_valid) begin
         r_if_valid <= 1'b0;
      end else if (w_load) begin
         r_if_valid <= 1'b1;
         r_if_idata <= imem_rsp_data;
         r_if_pc    <= r_inflight_pc;
      end else if (w_consume) begin
         r_if_valid <= 1'b0;
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] r_perf_fetch_cnt;
   logic [31:0] r_perf_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_perf_fetch_cnt <= '0;
         r_perf_stall_cnt <= '0;
      end else begin
         if (w_load) begin
            r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
         end
         if (r_if_valid && stall) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt = r_perf_fetch_cnt;
   assign perf_stall_cnt = r_perf_stall_cnt;
`endif

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_pc;
   assign if_valid       = r_if_valid;
   assign if_idata       = r_if_idata;
   assign if_pc          = r_if_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected request addresses and delivered instructions are
// queued as stimulus is driven and compared when the DUT issues/consumes them.
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_idata;
   logic [31:0] if_pc;

   logic        b_req_valid;
   logic        b_req_ready;
   logic [31:0] b_req_addr;
   logic        b_rsp_valid;
   logic [31:0] b_rsp_data;
   logic        b_if_valid;
   logic [31:0] b_if_idata;
   logic [31:0] b_if_pc;

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
   logic [31:0] b_perf_fetch_cnt;
   logic [31:0] b_perf_stall_cnt;
`endif

   int          checks = 0;
   int          errors = 0;
   int          rsp_cnt = -1;
   int          mem_lat = 1;
   logic [31:0] rsp_addr;
   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_out_q[$];

   instr_fetch_unit u_dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_idata       (if_idata),
      .if_pc          (if_pc)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (b_req_valid),
      .imem_req_ready (b_req_ready),
      .imem_req_addr  (b_req_addr),
      .imem_rsp_valid (b_rsp_valid),
      .imem_rsp_data  (b_rsp_data),
      .stall          (1'b0),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .if_valid       (b_if_valid),
      .if_idata       (b_if_idata),
      .if_pc          (b_if_pc)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt (b_perf_fetch_cnt),
      .perf_stall_cnt (b_perf_stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return 32'h0000_0013 ^ (a << 8);
   endfunction

   // One clock of the memory model plus scoreboard; entered and left 1 time unit after a rising edge.
   task automatic cycle();
      logic [31:0] ea;
      logic [63:0] eo;
      imem_rsp_valid = 1'b0;
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(rsp_addr);
            rsp_cnt        = -1;
         end
      end
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
         checks++;
         if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL req_addr: got unexpected request %h, expected none", imem_req_addr);
         end else begin
            ea = exp_addr_q.pop_front();
            if (imem_req_addr !== ea) begin
               errors++;
               $display("FAIL req_addr: got %h, expected %h", imem_req_addr, ea);
            end
         end
         rsp_addr = imem_req_addr;
         rsp_cnt  = mem_lat;
      end
      if (if_valid && !stall && !redirect_valid) begin
         checks++;
         if (exp_out_q.size() == 0) begin
            errors++;
            $display("FAIL if_out: got unexpected pc=%h data=%h, expected none", if_pc, if_idata);
         end else begin
            eo = exp_out_q.pop_front();
            if ({if_pc, if_idata} !== eo) begin
               errors++;
               $display("FAIL if_out: got pc=%h data=%h, expected pc=%h data=%h",
                        if_pc, if_idata, eo[63:32], eo[31:0]);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_fetch(input logic [31:0] a);
      exp_addr_q.push_back(a);
      exp_out_q.push_back({a, mem_data(a)});
   endtask

   task automatic run_until_done();
      int n;
      n = 0;
      while ((exp_addr_q.size() != 0 || exp_out_q.size() != 0) && n < 40) begin
         cycle();
         n++;
         if (exp_addr_q.size() == 0) imem_req_ready = 1'b0;
      end
      checks++;
      if (exp_addr_q.size() != 0 || exp_out_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d addr / %0d out pending, expected 0",
                  exp_addr_q.size(), exp_out_q.size());
         exp_addr_q.delete();
         exp_out_q.delete();
      end
      imem_req_ready = 1'b0;
   endtask

   task automatic reset_pulse();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      b_req_ready    = 1'b0;
      b_rsp_valid    = 1'b0;
      rsp_cnt        = -1;
      mem_lat        = 1;
      reset          = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      b_req_ready    = 1'b0;
      b_rsp_valid    = 1'b0;
      b_rsp_data     = '0;
      @(posedge clk);
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b, expected 0", imem_req_valid); end
      checks++;
      if ({if_valid, if_idata, if_pc} !== 65'd0) begin
         errors++; $display("FAIL rst_outputs: got v=%b d=%h pc=%h, expected all zero", if_valid, if_idata, if_pc);
      end
      checks++;
      if (b_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_pc_param: got %h, expected fffffffc", b_req_addr); end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if ({perf_fetch_cnt, perf_stall_cnt} !== 64'd0) begin
         errors++; $display("FAIL rst_perf: got %h/%h, expected 0/0", perf_fetch_cnt, perf_stall_cnt);
      end
`endif
      reset = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errors++; $display("FAIL first_req: got v=%b addr=%h, expected v=1 addr=00000000", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_basic_fetch();
      reset_pulse();
      imem_req_ready = 1'b1;
      push_fetch(32'h0);
      push_fetch(32'h4);
      push_fetch(32'h8);
      cycle();
      cycle();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_idata !== 32'h0000_0013) begin
         errors++; $display("FAIL basic_first_out: got v=%b pc=%h d=%h, expected v=1 pc=00000000 d=00000013", if_valid, if_pc, if_idata);
      end
      run_until_done();
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (perf_fetch_cnt !== 32'd3) begin errors++; $display("FAIL perf_fetch: got %0d, expected 3", perf_fetch_cnt); end
`endif
   endtask

   task automatic test_stall();
      int n;
      reset_pulse();
      imem_req_ready = 1'b1;
      push_fetch(32'h0);
      push_fetch(32'h4);
      n = 0;
      while (!(if_valid && if_pc == 32'h4) && n < 20) begin
         cycle();
         n++;
      end
      stall = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b, expected 0 (cycle %0d)", imem_req_valid, i); end
         cycle();
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_idata !== mem_data(32'h4)) begin
            errors++; $display("FAIL stall_hold: got v=%b pc=%h d=%h, expected v=1 pc=00000004 d=%h", if_valid, if_pc, if_idata, mem_data(32'h4));
         end
      end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d, expected 3", perf_stall_cnt); end
`endif
      stall = 1'b0;
      push_fetch(32'h8);
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
         errors++; $display("FAIL stall_release: got v=%b addr=%h, expected v=1 addr=00000008", imem_req_valid, imem_req_addr);
      end
      run_until_done();
   endtask

   task automatic test_redirect_wait();
      reset_pulse();
      mem_lat        = 3;
      imem_req_ready = 1'b1;
      exp_addr_q.push_back(32'h0);
      cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      push_fetch(32'h100);
      cycle();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drain_req_valid: got %b, expected 0", imem_req_valid); end
      cycle();
      cycle();
      checks++;
      if (if_valid !== 1'b0) begin errors++; $display("FAIL drain_discard: got if_valid=%b, expected 0", if_valid); end
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
         errors++; $display("FAIL redirect_wait_addr: got v=%b addr=%h, expected v=1 addr=00000100", imem_req_valid, imem_req_addr);
      end
      run_until_done();
   endtask

   task automatic test_redirect_collide();
      reset_pulse();
      imem_req_ready = 1'b1;
      exp_addr_q.push_back(32'h0);
      cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      push_fetch(32'h200);
      cycle();
      redirect_valid = 1'b0;
      checks++;
      if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
         errors++; $display("FAIL redirect_rsp: got if_v=%b req_v=%b addr=%h, expected 0/1/00000200", if_valid, imem_req_valid, imem_req_addr);
      end
      run_until_done();
      // Redirect together with the 0x204 handshake, then a second unaligned redirect while draining.
      mem_lat        = 2;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      exp_addr_q.push_back(32'h204);
      push_fetch(32'h402);
      cycle();
      redirect_pc = 32'h402;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL collide_drain: got req_valid=%b, expected 0", imem_req_valid); end
      cycle();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drain_redirect_hold: got req_valid=%b, expected 0", imem_req_valid); end
      cycle();
      checks++;
      if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h402) begin
         errors++; $display("FAIL drain_exit: got if_v=%b req_v=%b addr=%h, expected 0/1/00000402", if_valid, imem_req_valid, imem_req_addr);
      end
      run_until_done();
   endtask

   task automatic test_reset_async();
      reset_pulse();
      imem_req_ready = 1'b1;
      exp_addr_q.push_back(32'h0);
      cycle();
      imem_req_ready = 1'b0;
      stall          = 1'b1;
      cycle();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_idata !== 32'h13) begin
         errors++; $display("FAIL pre_async_out: got v=%b pc=%h d=%h, expected v=1 pc=00000000 d=00000013", if_valid, if_pc, if_idata);
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({if_valid, if_idata, if_pc} !== 65'd0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
         errors++; $display("FAIL async_reset: got v=%b d=%h pc=%h rv=%b ra=%h, expected all zero",
                            if_valid, if_idata, if_pc, imem_req_valid, imem_req_addr);
      end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if ({perf_fetch_cnt, perf_stall_cnt} !== 64'd0) begin
         errors++; $display("FAIL async_perf: got %h/%h, expected 0/0", perf_fetch_cnt, perf_stall_cnt);
      end
`endif
      @(posedge clk);
      #1;
      reset = 1'b1;
      stall = 1'b0;
      // Reset mid-WAIT; the abandoned response later arrives while the FSM is back in REQ.
      mem_lat        = 3;
      imem_req_ready = 1'b1;
      exp_addr_q.push_back(32'h0);
      cycle();
      imem_req_ready = 1'b0;
      cycle();
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || if_valid !== 1'b0) begin
         errors++; $display("FAIL reset_mid_wait: got rv=%b ra=%h v=%b, expected 0/00000000/0", imem_req_valid, imem_req_addr, if_valid);
      end
      cycle();
      reset = 1'b1;
      cycle();
      checks++;
      if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errors++; $display("FAIL stray_rsp: got v=%b rv=%b ra=%h, expected 0/1/00000000", if_valid, imem_req_valid, imem_req_addr);
      end
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      push_fetch(32'h0);
      run_until_done();
   endtask

   task automatic test_pc_wrap();
      reset_pulse();
      #1;
      checks++;
      if (b_req_valid !== 1'b1 || b_req_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_first: got v=%b addr=%h, expected v=1 addr=fffffffc", b_req_valid, b_req_addr);
      end
      b_req_ready = 1'b1;
      cycle();
      b_req_ready = 1'b0;
      b_rsp_valid = 1'b1;
      b_rsp_data  = 32'hCAFE_0001;
      cycle();
      b_rsp_valid = 1'b0;
      checks++;
      if (b_if_valid !== 1'b1 || b_if_pc !== 32'hFFFF_FFFC || b_if_idata !== 32'hCAFE_0001) begin
         errors++; $display("FAIL wrap_out: got v=%b pc=%h d=%h, expected v=1 pc=fffffffc d=cafe0001", b_if_valid, b_if_pc, b_if_idata);
      end
      checks++;
      if (b_req_valid !== 1'b1 || b_req_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_next: got v=%b addr=%h, expected v=1 addr=00000000", b_req_valid, b_req_addr);
      end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (b_perf_fetch_cnt !== 32'd1 || b_perf_stall_cnt !== 32'd0) begin
         errors++; $display("FAIL wrap_perf: got %0d/%0d, expected 1/0", b_perf_fetch_cnt, b_perf_stall_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_stall();
      test_redirect_wait();
      test_redirect_collide();
      test_reset_async();
      test_pc_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
